// File: rtl/hough_edge_scanner.sv
// Raster-scans a region of interest of the edge BRAM and streams the {y, x}
// coordinates of pixels above THRESHOLD into the Hough edge FIFO.
module hough_edge_scanner #(
    parameter  int WIDTH     = 1280,
    parameter  int HEIGHT    = 720,
    parameter  int X_MIN     = 0,
    parameter  int X_MAX     = WIDTH - 1,
    parameter  int Y_MIN     = 0,
    parameter  int Y_MAX     = HEIGHT - 1,
    parameter  int THRESHOLD = 0,
    localparam int XW        = $clog2(WIDTH),
    localparam int YW        = $clog2(HEIGHT),
    localparam int AW        = $clog2(WIDTH * HEIGHT),
    localparam int CW        = $clog2(WIDTH * HEIGHT + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [AW-1:0]     bram_rd_addr,
    input  logic [7:0]        bram_rd_data,
    output logic [YW+XW-1:0]  edge_din,
    output logic              edge_wr_en,
    input  logic              edge_full,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     edge_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [XW-1:0] XMIN_L  = XW'(X_MIN);
    localparam logic [XW-1:0] XMAX_L  = XW'(X_MAX);
    localparam logic [YW-1:0] YMIN_L  = YW'(Y_MIN);
    localparam logic [YW-1:0] YMAX_L  = YW'(Y_MAX);
    localparam logic [AW-1:0] ROW0_A  = AW'(Y_MIN * WIDTH);
    localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);
    localparam logic [AW-1:0] XMIN_A  = AW'(X_MIN);
    localparam logic [7:0]    THR_L   = 8'(THRESHOLD);

    state_t          state_reg;
    logic [XW-1:0]   x_reg;
    logic [YW-1:0]   y_reg;
    logic [AW-1:0]   row_base_reg;
    logic [AW-1:0]   addr_reg;
    logic            pend_valid_reg;
    logic [XW-1:0]   pend_x_reg;
    logic [YW-1:0]   pend_y_reg;
    logic            hold_valid_reg;
    logic [XW-1:0]   hold_x_reg;
    logic [YW-1:0]   hold_y_reg;
    logic [CW-1:0]   count_reg;
    logic            busy_reg;
    logic            done_reg;

    logic            ret_edge;
    logic            wr_en;
    logic            issue;
    logic            last_x;
    logic            last_px;
    logic [AW-1:0]   next_row_base;

    assign ret_edge      = pend_valid_reg && (bram_rd_data > THR_L);
    assign wr_en         = !edge_full && (hold_valid_reg || ret_edge);
    // Issuing is blocked while a held edge is waiting so pend and hold never coexist.
    assign issue         = (state_reg == SCAN) && !edge_full && !hold_valid_reg;
    assign last_x        = (x_reg == XMAX_L);
    assign last_px       = last_x && (y_reg == YMAX_L);
    assign next_row_base = row_base_reg + WIDTH_A;

    assign bram_rd_addr = addr_reg;
    assign edge_din     = hold_valid_reg ? {hold_y_reg, hold_x_reg} : {pend_y_reg, pend_x_reg};
    assign edge_wr_en   = wr_en;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign edge_count   = count_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            x_reg          <= '0;
            y_reg          <= '0;
            row_base_reg   <= '0;
            addr_reg       <= '0;
            pend_valid_reg <= 1'b0;
            pend_x_reg     <= '0;
            pend_y_reg     <= '0;
            hold_valid_reg <= 1'b0;
            hold_x_reg     <= '0;
            hold_y_reg     <= '0;
            count_reg      <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg       <= 1'b0;
            pend_valid_reg <= issue;
            if (issue) begin
                pend_x_reg <= x_reg;
                pend_y_reg <= y_reg;
            end

            if (wr_en)
                count_reg <= count_reg + CW'(1);

            if (hold_valid_reg) begin
                if (!edge_full)
                    hold_valid_reg <= 1'b0;
            end else if (ret_edge && edge_full) begin
                hold_valid_reg <= 1'b1;
                hold_x_reg     <= pend_x_reg;
                hold_y_reg     <= pend_y_reg;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= SCAN;
                        busy_reg     <= 1'b1;
                        x_reg        <= XMIN_L;
                        y_reg        <= YMIN_L;
                        row_base_reg <= ROW0_A;
                        addr_reg     <= ROW0_A + XMIN_A;
                        count_reg    <= '0;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        if (last_px) begin
                            state_reg <= DRAIN;
                        end else if (last_x) begin
                            x_reg        <= XMIN_L;
                            y_reg        <= y_reg + YW'(1);
                            row_base_reg <= next_row_base;
                            addr_reg     <= next_row_base + XMIN_A;
                        end else begin
                            x_reg    <= x_reg + XW'(1);
                            addr_reg <= addr_reg + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!pend_valid_reg && !hold_valid_reg) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hough_edge_scanner.sv
// Scoreboard bench: a full-frame scanner (a) and an ROI/threshold scanner (b)
// on 8x4 images, each fed by its own registered-read BRAM model.
module tb_hough_edge_scanner;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- DUT a: full ROI, THRESHOLD 0 ----------------
    logic       start_a, wr_en_a, full_a, busy_a, done_a;
    logic [4:0] addr_a, dout_a;
    logic [7:0] rd_data_a;
    logic [5:0] count_a;
    logic [7:0] mem_a [32];
    logic [4:0] q_a [$];

    hough_edge_scanner #(.WIDTH(8), .HEIGHT(4), .THRESHOLD(0)) dut_a (
        .clock(clock), .reset(reset), .start(start_a),
        .bram_rd_addr(addr_a), .bram_rd_data(rd_data_a),
        .edge_din(dout_a), .edge_wr_en(wr_en_a), .edge_full(full_a),
        .busy(busy_a), .done(done_a), .edge_count(count_a)
    );

    always @(posedge clock) rd_data_a <= mem_a[addr_a];

    // ---------------- DUT b: ROI x 2..5, y 1..2, THRESHOLD 48 ----------------
    logic       start_b, wr_en_b, full_b, busy_b, done_b;
    logic [4:0] addr_b, dout_b;
    logic [7:0] rd_data_b;
    logic [5:0] count_b;
    logic [7:0] mem_b [32];
    logic [4:0] q_b [$];

    hough_edge_scanner #(.WIDTH(8), .HEIGHT(4), .X_MIN(2), .X_MAX(5),
                         .Y_MIN(1), .Y_MAX(2), .THRESHOLD(48)) dut_b (
        .clock(clock), .reset(reset), .start(start_b),
        .bram_rd_addr(addr_b), .bram_rd_data(rd_data_b),
        .edge_din(dout_b), .edge_wr_en(wr_en_b), .edge_full(full_b),
        .busy(busy_b), .done(done_b), .edge_count(count_b)
    );

    always @(posedge clock) rd_data_b <= mem_b[addr_b];

    // Monitors: pop one expected coordinate per FIFO write.
    always begin
        @(negedge clock);
        #1;
        if (full_a)
            check("wr_during_full_a", int'(wr_en_a), 0);
        if (wr_en_a) begin
            check("queue_nonempty_a", int'(q_a.size() > 0), 1);
            if (q_a.size() > 0) begin
                logic [4:0] e;
                e = q_a.pop_front();
                $display("a write y=%0d x=%0d exp y=%0d x=%0d", dout_a[4:3], dout_a[2:0], e[4:3], e[2:0]);
                check("coord_a", int'(dout_a), int'(e));
            end
        end
    end

    always begin
        @(negedge clock);
        #1;
        if (busy_b)
            check("roi_addr_b", int'((addr_b >= 10 && addr_b <= 13) || (addr_b >= 18 && addr_b <= 21)), 1);
        if (wr_en_b) begin
            check("queue_nonempty_b", int'(q_b.size() > 0), 1);
            if (q_b.size() > 0) begin
                logic [4:0] e;
                e = q_b.pop_front();
                $display("b write y=%0d x=%0d exp y=%0d x=%0d", dout_b[4:3], dout_b[2:0], e[4:3], e[2:0]);
                check("coord_b", int'(dout_b), int'(e));
            end
        end
    end

    task automatic load_expect_a(output int n);
        n = 0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                if (mem_a[y*8 + x] > 8'd0) begin
                    q_a.push_back({2'(y), 3'(x)});
                    n++;
                end
    endtask

    // mode 0: FIFO never full, 1: full during cycles 3..6, 2: full on odd cycles
    task automatic run_a(input string name, input int mode, input int mid_start, input int exp_done);
        int n, cyc;
        bit seen;
        load_expect_a(n);
        @(negedge clock);
        start_a = 1'b1;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 300) begin
            @(negedge clock);
            cyc++;
            start_a = (mid_start != 0) && (cyc == 5);
            full_a  = (mode == 1 && cyc >= 3 && cyc <= 6) || (mode == 2 && (cyc % 2) == 1);
            if (cyc == 1) begin
                check({name, "_busy_c1"}, int'(busy_a), 1);
                check({name, "_addr_c1"}, int'(addr_a), 0);
            end
            if (done_a) seen = 1;
        end
        full_a = 1'b0;
        check({name, "_done_seen"}, int'(seen), 1);
        if (exp_done >= 0)
            check({name, "_done_cycle"}, cyc, exp_done);
        @(negedge clock);
        check({name, "_busy_after"}, int'(busy_a), 0);
        check({name, "_done_pulse"}, int'(done_a), 0);
        check({name, "_count"}, int'(count_a), n);
        check({name, "_queue_empty"}, q_a.size(), 0);
        $display("scan %s edges=%0d done_cycle=%0d", name, count_a, cyc);
    endtask

    task automatic run_b(input string name, input int exp_done);
        int n, cyc;
        bit seen;
        n = 0;
        for (int y = 1; y <= 2; y++)
            for (int x = 2; x <= 5; x++)
                if (mem_b[y*8 + x] > 8'd48) begin
                    q_b.push_back({2'(y), 3'(x)});
                    n++;
                end
        @(negedge clock);
        start_b = 1'b1;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 100) begin
            @(negedge clock);
            cyc++;
            start_b = 1'b0;
            if (cyc == 1)
                check({name, "_addr_c1"}, int'(addr_b), 10);
            if (done_b) seen = 1;
        end
        check({name, "_done_seen"}, int'(seen), 1);
        check({name, "_done_cycle"}, cyc, exp_done);
        @(negedge clock);
        check({name, "_busy_after"}, int'(busy_b), 0);
        check({name, "_count"}, int'(count_b), n);
        check({name, "_queue_empty"}, q_b.size(), 0);
        $display("scan %s edges=%0d done_cycle=%0d", name, count_b, cyc);
    endtask

    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        full_a  = 1'b0;
        full_b  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = 8'd0;
            mem_b[i] = 8'd0;
        end
        #3;
        check("rst_addr", int'(addr_a), 0);
        check("rst_din", int'(dout_a), 0);
        check("rst_wr_en", int'(wr_en_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_count", int'(count_a), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        run_a("zeros", 0, 0, 35);

        mem_a[1*8 + 3] = 8'd200;
        mem_a[3*8 + 7] = 8'd13;
        mem_a[0]       = 8'd1;
        run_a("three_px", 0, 0, 35);

        for (int i = 0; i < 32; i++) mem_a[i] = 8'd255;
        run_a("full_3to6", 1, 0, -1);
        run_a("full_toggle", 2, 0, -1);

        for (int i = 0; i < 32; i++)
            mem_a[i] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        run_a("mid_start", 0, 1, 35);

        // Abort a scan with reset, then start a fresh one.
        begin
            int n;
            load_expect_a(n);
            @(negedge clock);
            start_a = 1'b1;
            @(negedge clock);
            start_a = 1'b0;
            repeat (10) @(negedge clock);
            #3;
            reset = 1'b1;
            #1;
            check("abort_busy", int'(busy_a), 0);
            check("abort_count", int'(count_a), 0);
            check("abort_addr", int'(addr_a), 0);
            check("abort_wr_en", int'(wr_en_a), 0);
            check("abort_done", int'(done_a), 0);
            q_a.delete();
            @(negedge clock);
            reset = 1'b0;
        end
        run_a("after_reset", 0, 0, 35);

        for (int i = 0; i < 32; i++) mem_b[i] = 8'd255;
        run_b("roi_all", 11);
        for (int i = 0; i < 32; i++) mem_b[i] = (i % 2 == 1) ? 8'd49 : 8'd48;
        run_b("roi_thresh", 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hough_edge_scanner.md
# hough_edge_scanner

Reads the finished hysteresis edge map out of the shared edge BRAM once the hysteresis stage pulses `hough_start`. Scans a rectangular region of interest in raster order and pushes the (x, y) coordinate of every pixel whose value exceeds a threshold into the edge FIFO that feeds the Hough accumulator. Counts emitted edges and pulses `done` after the last coordinate is accepted.

## Interface
- WIDTH, 1280, image width in pixels (BRAM row stride)
- HEIGHT, 720, image height in pixels
- X_MIN, 0 / X_MAX, WIDTH-1, inclusive ROI column bounds
- Y_MIN, 0 / Y_MAX, HEIGHT-1, inclusive ROI row bounds
- THRESHOLD, 0, pixel is an edge iff value > THRESHOLD (unsigned 8-bit compare)
- Derived: XW = $clog2(WIDTH), YW = $clog2(HEIGHT), AW = $clog2(WIDTH*HEIGHT), CW = $clog2(WIDTH*HEIGHT+1)

- clock  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse from hysteresis `hough_start`
- bram_rd_addr  out  AW  registered read address into edge BRAM
- bram_rd_data  in  8  BRAM data, valid one cycle after address is presented
- edge_din  out  YW+XW  {y, x}, y in upper YW bits
- edge_wr_en  out  1  FIFO write strobe
- edge_full  in  1  FIFO full
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at end of scan
- edge_count  out  CW  edges emitted in current/last scan

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: start=1 -> SCAN; load x=X_MIN, y=Y_MIN, row_base=Y_MIN*WIDTH (constant), bram_rd_addr=row_base+X_MIN, edge_count=0. start ignored in every other state.
- Issue condition in SCAN: !edge_full && !hold_valid. On issue: pend_valid<=1, pend_x<=x, pend_y<=y; advance x; at x==X_MAX wrap x=X_MIN, y++, row_base+=WIDTH (adder, no multiplier); bram_rd_addr <= row_base+x of next pixel. Issue of (X_MAX, Y_MAX) -> DRAIN. No issue -> pend_valid<=0, address held.
- Return path (pend_valid=1, data=bram_rd_data): data<=THRESHOLD -> dropped. Edge and !edge_full -> edge_wr_en=1, edge_din={pend_y,pend_x}, edge_count++. Edge and edge_full -> captured in 1-entry hold register (hold_valid<=1).
- Hold drain: hold_valid && !edge_full -> edge_wr_en=1 with held coords, edge_count++, hold_valid<=0. Pending and hold are never simultaneously valid (issue blocked while hold_valid or full).
- edge_wr_en is combinational from registered state and edge_full; never asserted when edge_full=1.
- DRAIN: wait until pend_valid=0 and hold_valid=0 -> DONE.
- DONE: done=1 for one cycle -> IDLE. edge_count holds its value until next start.
- edge_count never wraps (max ROI size < 2^CW).

## Timing
- Reset values: bram_rd_addr=0, edge_din=0, edge_wr_en=0, busy=0, done=0, edge_count=0, state IDLE, pend/hold invalid. Reset mid-scan aborts immediately; no partial done.
- start sampled cycle 0 -> busy=1 and first address on bram_rd_addr in cycle 1 -> earliest edge_wr_en cycle 2.
- Throughput 1 pixel/cycle with edge_full=0. N = (X_MAX-X_MIN+1)*(Y_MAX-Y_MIN+1): issues cycles 1..N, last return cycle N+1, DRAIN->DONE, done=1 in cycle N+3, busy falls cycle N+4.
- edge_full asserted in return cycle: that edge held, issue stops; resumes the cycle after hold drains. No coordinate lost or duplicated.
- edge_full toggling every cycle: output order remains strict raster.

## Test plan
- WIDTH=8, HEIGHT=4, full ROI, all-zero BRAM, start -> no edge_wr_en, done in cycle 35, edge_count=0.
- Same size, pixels (3,1)=200, (7,3)=13, (0,0)=1 -> writes {1,3}, {3,7}, {0,0} in raster order ({0,0},{1,3},{3,7}), edge_count=3.
- ROI X 2..5, Y 1..2, all pixels 255 -> 8 writes, addresses 10..13, 18..21 only, done cycle 11.
- All pixels 255, edge_full high cycles 3-6 -> hold captures second pixel, no write during full, sequence contiguous (0,0),(0,1),... with no gaps/duplicates, edge_count=32.
- THRESHOLD=48, pixels 48 and 49 -> only 49 emitted.
- Reset asserted mid-SCAN, then start -> fresh scan from (X_MIN,Y_MIN), edge_count restarts at 0; start pulse during SCAN ignored.
